pwm_generator: RTL
==================

Name: pwm_generator

Overview:
- Downstream consumer of the clock divider's output.
- Counts divided ticks to produce a single PWM waveform with programmable period, duty and polarity.
- Period and duty are double-buffered. A write lands in shadow registers and takes effect only at a period boundary, so the output never glitches mid-period.
- Sits between the divider and the output pin.

Parameters:
PWM_WIDTH, 8, width of the period, duty and internal counter.

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  synchronous active-low reset
tick  input  1  count enable from the clock divider, sampled at posedge clk; held high means count every cycle
wr  input  1  single-cycle write strobe; captures duty_in/period_in into the shadow registers
duty_in  input  PWM_WIDTH  requested active-tick count per period
period_in  input  PWM_WIDTH  requested period minus one (period = period_in+1 ticks)
en  input  1  generator enable (level)
pol  input  1  output polarity; 1 inverts pwm_out
pwm_out  output  1  registered PWM output
period_end  output  1  one-cycle pulse when the counter wraps
pending  output  1  shadow holds values not yet applied

Behaviour:
- Reset (rst_n=0 at posedge):
  - cnt, duty_act, period_act, duty_sh, period_sh all clear to 0.
  - pending, pwm_out and period_end clear to 0.
  - Reset overrides every other input.
- Shadow write: wr=1 sets duty_sh<=duty_in, period_sh<=period_in and pending<=1.
- Boundary condition: boundary = en & tick & (cnt==period_act).
- Counter:
  - en=0: cnt<=0.
  - en&tick&~boundary: cnt<=cnt+1.
  - boundary: cnt<=0.
  - en&~tick: cnt holds.
  - cnt never exceeds period_act; no arithmetic overflow is possible.
- Active register load:
  - Loads occur on boundary, or on any cycle with en=0.
  - Source is the shadow registers.
  - If wr coincides with a load, the load bypasses the shadow and takes duty_in/period_in directly, and pending<=0.
  - Otherwise a load clears pending.
  - With en=0 the configuration is applied every cycle, so a newly enabled generator starts with the latest values.
- Output, registered with 1-cycle latency:
  - pwm_out(n+1) = pol XOR (en(n) & (cnt(n) < duty_act(n))).
  - Compare is unsigned at PWM_WIDTH bits.
  - duty_act=0 gives constantly inactive.
  - duty_act>period_act gives constantly active; no wrap in the compare.
  - en=0 drives pwm_out to pol, the inactive level, one cycle later.
- period_end(n+1) = boundary(n), so it pulses for exactly one clk cycle per period.
- Duty and period units are ticks. High time = duty_act ticks; period = (period_act+1) ticks.
- Disabling mid-period:
  - Counter returns to 0 next cycle.
  - No period_end pulse is generated.
  - Re-enabling starts a fresh period at cnt=0.
- pol changes take effect on pwm_out on the next cycle and are not buffered.
- Reset mid-period: all state returns to the reset values above on the next edge, and the shadow contents are lost.

Test Plan:
1. Reset held 2 cycles with pol=1 -> pwm_out=0, period_end=0, pending=0; release reset with en=0 -> pwm_out=1 one cycle later.
2. tick=1, pol=0, period_in=9, duty_in=3, wr pulse with en=0, then en=1 -> pwm_out high 3 cycles / low 7 cycles repeating; period_end pulses every 10 cycles, aligned to the wrap.
3. Edge duties with period_in=9:
   - duty 0 -> pwm_out stays low.
   - duty 10 -> stays high.
   - period_in=255, duty_in=255 -> high 255 of every 256 cycles, no counter overflow.
4. Running with period 10/duty 3, write duty_in=7 while cnt=4 -> pending=1; current period still shows 3 high; the next period shows 7 high; pending clears on the boundary cycle.
5. tick high one cycle in four, period_in=3, duty_in=2 -> pwm_out high 8 clk / low 8 clk per 16-clk period; period_end once per 16 clks; wr coincident with boundary applies the new values in the immediately following period.
6. Deassert en at cnt=5 -> pwm_out=pol next cycle, cnt=0, no period_end; assert rst_n=0 mid-period -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/pwm_generator.sv
// pwm_generator: tick-driven PWM with double-buffered period/duty and programmable polarity
module pwm_generator #(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 wr,
  input  logic [PWM_WIDTH-1:0] duty_in,
  input  logic [PWM_WIDTH-1:0] period_in,
  input  logic                 en,
  input  logic                 pol,
  output logic                 pwm_out,
  output logic                 period_end,
  output logic                 pending
);
  logic [PWM_WIDTH-1:0] cnt_q, cnt_d, duty_act_q, duty_act_d, period_act_q, period_act_d;
  logic [PWM_WIDTH-1:0] duty_sh_q, duty_sh_d, period_sh_q, period_sh_d;
  logic pending_q, pending_d, pwm_q, pwm_d, period_end_q, boundary, load;
  assign boundary = en & tick & (cnt_q == period_act_q);
  // a disabled generator reloads every cycle so re-enabling picks up the latest config
  assign load = boundary | ~en;
  always_comb begin
    cnt_d        = load ? '0 : cnt_q + PWM_WIDTH'(tick);
    duty_sh_d    = wr ? duty_in : duty_sh_q;
    period_sh_d  = wr ? period_in : period_sh_q;
    duty_act_d   = load ? (wr ? duty_in : duty_sh_q) : duty_act_q;
    period_act_d = load ? (wr ? period_in : period_sh_q) : period_act_q;
    pending_d    = load ? 1'b0 : (wr | pending_q);
    pwm_d        = pol ^ (en & (cnt_q < duty_act_q));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      duty_act_q   <= '0;
      period_act_q <= '0;
      duty_sh_q    <= '0;
      period_sh_q  <= '0;
      pending_q    <= 1'b0;
      pwm_q        <= 1'b0;
      period_end_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      duty_act_q   <= duty_act_d;
      period_act_q <= period_act_d;
      duty_sh_q    <= duty_sh_d;
      period_sh_q  <= period_sh_d;
      pending_q    <= pending_d;
      pwm_q        <= pwm_d;
      period_end_q <= boundary;
    end
  end
  assign pwm_out    = pwm_q;
  assign period_end = period_end_q;
  assign pending    = pending_q;
endmodule
